risc16b_mem: RTL and testbench

//  Memory responder for the risc16b core: serves the core's instruction fetch port and its data load/store port from one shared word RAM.

---
 rtl/risc16b_mem.sv | 128 ++++++++++++
 tb/tb_risc16b_mem.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc16b_mem.sv
// risc16b_mem: memory responder for the risc16b core.
// One shared 16-bit word RAM serves the instruction fetch port and the data
// load/store port. A host loader fills the RAM over a valid/ready word stream
// while the core is held in reset. A full-word store to HALT_ADDR stops the
// core and latches a halt code and cycle count.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   i_addr, i_oe, i_din         instruction fetch (asynchronous read)
//   d_addr, d_oe, d_din         data read (asynchronous read)
//   d_dout, d_we                data write, big-endian byte lanes
//   cpu_rst                     active-high reset to the core
//   ld_valid, ld_ready,
//   ld_data, ld_last            host loader word stream
//   ld_restart                  pulse: back to LOAD from RUN or HALT
//   halted, halt_code           halt status and stored code
//   run_cycles                  clock edges spent in RUN (saturating)
module risc16b_mem #(
  parameter int          MEM_AW    = 11,
  parameter logic [15:0] HALT_ADDR = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_addr,
  input  logic        i_oe,
  output logic [15:0] i_din,
  input  logic [15:0] d_addr,
  input  logic        d_oe,
  output logic [15:0] d_din,
  input  logic [15:0] d_dout,
  input  logic [1:0]  d_we,
  output logic        cpu_rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  input  logic        ld_restart,
  output logic        halted,
  output logic [15:0] halt_code,
  output logic [31:0] run_cycles
);

  typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [MEM_AW-1:0] ld_ptr;
  logic [15:0]       mem [0:(1 << MEM_AW) - 1];

  logic ld_beat;
  logic halt_hit;
  logic ram_we;
  logic unused_addr;

  // Byte address bit 0 and bits above the RAM depth do not index RAM.
  assign unused_addr = ^{i_addr[15:MEM_AW+1], i_addr[0]};

  assign ld_beat  = ld_valid && ld_ready;
  assign halt_hit = (d_we == 2'b11) && (d_addr == HALT_ADDR);
  // Any store aimed at the halt register never reaches RAM, byte stores included.
  assign ram_we   = rst_n && (state == RUN) && (d_we != 2'b00) && (d_addr != HALT_ADDR);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Next-state logic; restart wins over a simultaneous halt store.
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD: if (ld_beat && ld_last) state_nxt = RUN;
      RUN: begin
        if (ld_restart)    state_nxt = LOAD;
        else if (halt_hit) state_nxt = HALT;
      end
      HALT: if (ld_restart) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Output logic
  always_comb begin
    ld_ready = rst_n && (state == LOAD);
  end

  // Registered status and counters; cpu_rst/halted follow the next state so
  // they change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rst    <= 1'b1;
      halted     <= 1'b0;
      halt_code  <= '0;
      run_cycles <= '0;
      ld_ptr     <= '0;
    end else begin
      cpu_rst <= (state_nxt != RUN);
      halted  <= (state_nxt == HALT);

      if (state == LOAD) begin
        if (ld_beat) ld_ptr <= ld_last ? '0 : ld_ptr + 1'b1;
      end else if (ld_restart) begin
        ld_ptr <= '0;
      end

      if ((state == RUN) && !ld_restart && halt_hit) halt_code <= d_dout;

      if ((state != LOAD) && (state_nxt == LOAD))
        run_cycles <= '0;
      else if ((state == RUN) && (run_cycles != '1))
        run_cycles <= run_cycles + 32'd1;
    end
  end

  // RAM: loader writes in LOAD, core writes in RUN; contents survive reset.
  always_ff @(posedge clk) begin
    if ((state == LOAD) && ld_beat) begin
      mem[ld_ptr] <= ld_data;
    end else if (ram_we) begin
      if (d_we[0]) mem[d_addr[MEM_AW:1]][15:8] <= d_dout[15:8];
      if (d_we[1]) mem[d_addr[MEM_AW:1]][7:0]  <= d_dout[7:0];
    end
  end

  assign i_din = i_oe ? mem[i_addr[MEM_AW:1]] : '0;
  assign d_din = d_oe ? mem[d_addr[MEM_AW:1]] : '0;

endmodule

// File: tb/tb_risc16b_mem.sv
// Self-checking bench for risc16b_mem: expected values are queued as
// stimulus is applied and compared when the DUT output is sampled.
module tb_risc16b_mem;

  localparam int MEM_AW = 11;
  localparam int S_DDIN = 0, S_IDIN = 1, S_CRST = 2, S_RDY = 3,
                 S_HALT = 4, S_CODE = 5, S_RUNC = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_addr, d_addr, d_dout, ld_data;
  logic        i_oe, d_oe, ld_valid, ld_last, ld_restart;
  logic [1:0]  d_we;
  logic [15:0] i_din, d_din, halt_code;
  logic        cpu_rst, ld_ready, halted;
  logic [31:0] run_cycles;

  risc16b_mem #(.MEM_AW(MEM_AW), .HALT_ADDR(16'hFFFE)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din),
    .d_addr(d_addr), .d_oe(d_oe), .d_din(d_din),
    .d_dout(d_dout), .d_we(d_we), .cpu_rst(cpu_rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_last(ld_last), .ld_restart(ld_restart),
    .halted(halted), .halt_code(halt_code), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;

  // Bench model
  logic [15:0]       model_mem [0:(1 << MEM_AW) - 1];
  logic [MEM_AW-1:0] m_ptr = '0;
  bit                m_run = 1'b0;
  int                rc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_DDIN:  return {16'h0, d_din};
      S_IDIN:  return {16'h0, i_din};
      S_CRST:  return {31'h0, cpu_rst};
      S_RDY:   return {31'h0, ld_ready};
      S_HALT:  return {31'h0, halted};
      S_CODE:  return {16'h0, halt_code};
      default: return run_cycles;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input logic [31:0] exp);
    sbq.push_back('{tag, sel, exp});
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (m_run) rc++;
    #1;
  endtask

  task automatic ld_beat(input logic [15:0] dat, input logic last);
    ld_valid = 1'b1; ld_data = dat; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    model_mem[m_ptr] = dat;
    m_ptr = last ? '0 : m_ptr + 1'b1;
    if (last) m_run = 1'b1;
  endtask

  task automatic model_store(input logic [15:0] a, input logic [1:0] we, input logic [15:0] dat);
    logic [MEM_AW-1:0] w;
    w = a[MEM_AW:1];
    if (!m_run) return;
    if (a == 16'hFFFE) begin
      if (we == 2'b11) m_run = 1'b0;
      return;
    end
    if (we[0]) model_mem[w][15:8] = dat[15:8];
    if (we[1]) model_mem[w][7:0]  = dat[7:0];
  endtask

  task automatic store(input logic [15:0] a, input logic [1:0] we, input logic [15:0] dat);
    bit was_run;
    was_run = m_run;
    d_addr = a; d_we = we; d_dout = dat;
    step();
    d_we = 2'b00;
    m_run = was_run;
    model_store(a, we, dat);
  endtask

  task automatic rd(input string tag, input logic [15:0] a);
    d_oe = 1'b1; d_addr = a;
    #1;
    expect_v(tag, S_DDIN, {16'h0, model_mem[a[MEM_AW:1]]});
    drain();
    d_oe = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_addr = '0; d_addr = '0; d_dout = '0; ld_data = '0;
    i_oe = 1'b0; d_oe = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
    ld_restart = 1'b0; d_we = 2'b00;
    step();
    // Loader beat offered during reset must be ignored
    ld_valid = 1'b1; ld_data = 16'h1234; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    expect_v("rst_cpu_rst", S_CRST, 1);
    expect_v("rst_ready",   S_RDY,  0);
    expect_v("rst_halted",  S_HALT, 0);
    expect_v("rst_code",    S_CODE, 0);
    expect_v("rst_runc",    S_RUNC, 0);
    drain();
    rst_n = 1'b1;
    #1;
    expect_v("load_ready", S_RDY, 1);
    drain();

    // Three-word image
    ld_beat(16'h8801, 1'b0);
    ld_beat(16'h0000, 1'b0);
    expect_v("cpu_rst_before_last", S_CRST, 1);
    drain();
    ld_beat(16'h0000, 1'b1);
    expect_v("cpu_rst_after_last", S_CRST, 0);
    expect_v("ready_after_last",   S_RDY,  0);
    expect_v("runc_at_entry",      S_RUNC, 0);
    drain();
    rd("mem0", 16'h0000);
    rd("mem1", 16'h0002);
    rd("mem2", 16'h0004);

    // Write then read-back; same-cycle reads see old contents
    store(16'h0010, 2'b11, 16'h1111);
    d_addr = 16'h0010; d_we = 2'b11; d_dout = 16'hBEEF;
    i_addr = 16'h0010; i_oe = 1'b1; d_oe = 1'b1;
    #1;
    expect_v("same_cyc_i", S_IDIN, 16'h1111);
    expect_v("same_cyc_d", S_DDIN, 16'h1111);
    drain();
    step();
    d_we = 2'b00;
    model_store(16'h0010, 2'b11, 16'hBEEF);
    expect_v("wr_readback_d", S_DDIN, 16'hBEEF);
    expect_v("wr_readback_i", S_IDIN, 16'hBEEF);
    drain();
    i_oe = 1'b0; d_oe = 1'b0;
    #1;
    expect_v("i_oe_low", S_IDIN, 0);
    drain();
    rd("alias_hi_bits", 16'h1011);

    // Byte lanes
    store(16'h0020, 2'b11, 16'h5555);
    store(16'h0020, 2'b01, 16'hAB00);
    rd("sb_even", 16'h0020);
    store(16'h0021, 2'b10, 16'h00CD);
    rd("sb_odd", 16'h0020);
    check("sb_model", {16'h0, model_mem[16]}, 32'h0000ABCD);

    // Byte store to halt register is dropped
    store(16'h0FFE, 2'b11, 16'h7777);
    store(16'hFFFE, 2'b10, 16'h00AA);
    expect_v("byte_halt_no_halt", S_HALT, 0);
    expect_v("byte_halt_running", S_CRST, 0);
    drain();
    rd("byte_halt_no_ram", 16'h0FFE);

    // Halt on the 100th RUN edge
    while (rc < 99) step();
    store(16'hFFFE, 2'b11, 16'h0042);
    expect_v("halt_flag", S_HALT, 1);
    expect_v("halt_code", S_CODE, 16'h0042);
    expect_v("halt_cpu_rst", S_CRST, 1);
    expect_v("halt_runc", S_RUNC, 100);
    drain();
    store(16'h0010, 2'b11, 16'h9999);
    step(); step();
    expect_v("halt_runc_held", S_RUNC, 100);
    drain();
    rd("halt_no_store", 16'h0010);
    rd("halt_no_ram", 16'h0FFE);

    // Restart from HALT
    ld_restart = 1'b1;
    step();
    ld_restart = 1'b0;
    m_ptr = '0; rc = 0;
    expect_v("rs_halted", S_HALT, 0);
    expect_v("rs_cpu_rst", S_CRST, 1);
    expect_v("rs_runc", S_RUNC, 0);
    expect_v("rs_ready", S_RDY, 1);
    drain();

    // Wrapping load: 2^MEM_AW + 1 words
    for (int unsigned i = 0; i <= (1 << MEM_AW); i++) begin
      if (i == (1 << MEM_AW)) ld_beat(16'hC0DE, 1'b1);
      else                    ld_beat(16'(i * 3 + 7), 1'b0);
    end
    expect_v("wrap_cpu_rst", S_CRST, 0);
    drain();
    rd("wrap_word0", 16'h0000);
    rd("wrap_word1", 16'h0002);
    rd("wrap_top",   16'h0FFE);

    // Reset in RUN
    rst_n = 1'b0;
    step();
    m_run = 1'b0; rc = 0; m_ptr = '0;
    expect_v("rr_cpu_rst", S_CRST, 1);
    expect_v("rr_ready", S_RDY, 0);
    expect_v("rr_runc", S_RUNC, 0);
    expect_v("rr_code", S_CODE, 0);
    drain();
    ld_valid = 1'b1; ld_data = 16'hDEAD; ld_last = 1'b1;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    expect_v("rr_no_accept", S_CRST, 1);
    drain();
    rd("rr_ram_kept", 16'h0000);
    rst_n = 1'b1;
    #1;
    expect_v("rr_ready_back", S_RDY, 1);
    drain();

    // Restart beats a simultaneous halt store
    ld_beat(16'h5A5A, 1'b1);
    rd("reload_word0", 16'h0000);
    d_addr = 16'hFFFE; d_we = 2'b11; d_dout = 16'h0077; ld_restart = 1'b1;
    step();
    d_we = 2'b00; ld_restart = 1'b0; m_run = 1'b0;
    expect_v("prio_halted", S_HALT, 0);
    expect_v("prio_cpu_rst", S_CRST, 1);
    expect_v("prio_code", S_CODE, 0);
    expect_v("prio_runc", S_RUNC, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
